i2s_tx: RTL and testbench
=========================

# i2s_tx

I2S transmitter for the audio effect chain. It accepts processed stereo samples from an effect block such as the flanger, using a per-channel valid/ack handshake, and buffers one sample per channel. It serializes the samples MSB-first onto a standard Philips I2S link (BCLK/LRCLK/SDATA) toward the DAC codec. The whole block runs in the system clock domain; BCLK and LRCLK are generated internally by division.

## Interface
Parameters:
- BCLK_DIV, 16: system clocks per BCLK half-period. Must be ≥ 2. At 100 MHz: BCLK 3.125 MHz, frame rate ≈ 48.8 kHz.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset. Low means reset.
- audio_in_0  in  24  left (channel 0) sample, unsigned 24-bit.
- audio_in_1  in  24  right (channel 1) sample.
- audio_in_vld  in  2  bit n = sample on audio_in_n valid; held by the source until acked.
- audio_in_ack  out  2  bit n = sample n accepted this cycle.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select: 0 = channel 0, 1 = channel 1.
- i2s_sdata  out  1  serial data.
- underrun  out  1  sticky flag: a slot started with an empty holding register.

## Operation
- Holding registers: hold_0 and hold_1 (24 b), each with a full flag.
- Handshake: audio_in_ack[n] = audio_in_vld[n] & ~full_n & rst (combinational).
  - Transfer happens on the clk edge where ack[n] = 1: hold_n ← audio_in_n and full_n ← 1.
  - Channels are independent; both may transfer in the same cycle.
- BCLK generator:
  - Counter div_cnt runs 0..BCLK_DIV-1; i2s_bclk toggles when div_cnt = BCLK_DIV-1.
  - A "fall" event is the cycle in which i2s_bclk toggles 1→0.
- Frame counter:
  - bit_cnt (6 b) increments on every fall event and wraps 63→0.
  - slot = bit_cnt[5] (0 = ch0, 1 = ch1); pos = bit_cnt[4:0].
- Shift register shreg (24 b), updated on fall events:
  - pos becomes 0 with full_slot = 1: shreg ← hold_slot and full_slot ← 0.
  - pos becomes 0 with full_slot = 0: shreg ← 0 and underrun ← 1.
  - pos 1..23: shift left one bit.
- i2s_sdata = shreg[23] for pos 0..23, and 0 for pos 24..31. It changes only on fall events.
- i2s_lrclk = bit 5 of (bit_cnt+1) mod 64. It therefore changes one BCLK before the MSB of the slot (I2S one-bit delay).
- Simultaneous load and capture for the same channel in one cycle:
  - The load wins; full is cleared that cycle.
  - ack uses the registered full flag, so ack stays 0 in that cycle. The capture happens on the next cycle.
- underrun stays set until reset.

## Timing
- Reset (rst low, asynchronous) forces:
  - div_cnt = 0, i2s_bclk = 0, bit_cnt = 63, shreg = 0.
  - full_0 = full_1 = 0, underrun = 0.
  - i2s_lrclk = 0, i2s_sdata = 0, audio_in_ack = 0.
  - Reset asserted mid-frame aborts the frame immediately and discards held samples.
- After rst rises:
  - First rising edge of i2s_bclk occurs after BCLK_DIV clk cycles.
  - First fall event occurs after 2·BCLK_DIV cycles. That event sets bit_cnt = 0 and loads ch0.
- Ack latency: 0 cycles (same cycle as vld) when the holding register is empty.
- Sample latency: from transfer to MSB on i2s_sdata = the time to the next slot start of that channel, at most 64 BCLK periods.
- Frame length: 64 BCLK = 128·BCLK_DIV clk cycles. LRCLK duty is exactly 50%.
- Data and LRCLK change on BCLK falling edges. The codec samples them on rising edges.

## Test plan
- Reset, then hold vld = 2'b00 for 2 frames (BCLK_DIV = 2) → BCLK period 4 clk, LRCLK period 256 clk, sdata constantly 0, underrun = 1 after the first slot start.
- Present audio_in_0 = 24'hA5A5A5 and audio_in_1 = 24'h0F0F01 with vld = 2'b11 before the first fall event → ack = 2'b11 for one cycle. On the rising edges, ch0 slot bits read A5A5A5 MSB-first followed by 8 zeros, and ch1 reads 0F0F01. LRCLK leads by one bit; underrun stays 0.
- Hold vld[0] high with a new sample while full_0 = 1 → ack[0] stays 0 until the fall event that loads ch0, then goes 1 on the following cycle. The sample appears in the next frame's ch0 slot.
- Raise vld[0] exactly in the load cycle → no ack in that cycle, ack on the next cycle, no sample lost or duplicated.
- Stream 8 frames of a ramp (ch0 = k, ch1 = ~k), with the source refilling each channel on ack → decoded output matches the input sequence in order and underrun stays 0.
- Assert rst low mid-slot (pos = 10) → all outputs read 0 within the same cycle. After release, the sequence restarts from the first-fall timing with the holding registers empty.

Source files
------------

// File: rtl/i2s_tx_if.sv
// Sample handshake between an effect block (source) and the I2S transmitter.
// Per-channel valid/ack; data is held by the source until its ack bit is seen.
interface i2s_tx_if;
  logic [23:0] audio_in_0;
  logic [23:0] audio_in_1;
  logic [1:0]  audio_in_vld;
  logic [1:0]  audio_in_ack;

  modport master (output audio_in_0, output audio_in_1, output audio_in_vld,
                  input  audio_in_ack);
  modport slave  (input  audio_in_0, input  audio_in_1, input  audio_in_vld,
                  output audio_in_ack);
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one holding register per channel, 64-BCLK frame,
// 24-bit MSB-first slots with one-bit LRCLK lead. BCLK/LRCLK divided from clk.
module i2s_tx #(
  parameter int BCLK_DIV = 16
) (
  input  logic      clk,
  input  logic      rst,
  i2s_tx_if.slave   aud,
  output logic      i2s_bclk,
  output logic      i2s_lrclk,
  output logic      i2s_sdata,
  output logic      underrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_cnt_inc;
  logic [23:0]   shreg;
  logic [23:0]   hold_0, hold_1;
  logic          full_0, full_1;
  logic [1:0]    ack;
  logic          tick, fall;
  logic          slot_nx;
  logic [4:0]    pos_nx;
  logic          slot_full;
  logic [23:0]   slot_hold;
  logic          load_0, load_1;

  assign tick        = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall        = tick & i2s_bclk;
  assign bit_cnt_inc = bit_cnt + 6'd1;
  assign slot_nx     = bit_cnt_inc[5];
  assign pos_nx      = bit_cnt_inc[4:0];
  assign slot_full   = slot_nx ? full_1 : full_0;
  assign slot_hold   = slot_nx ? hold_1 : hold_0;

  // A slot load only drains a register that is actually full; an empty slot
  // is an underrun instead.
  assign load_0 = fall & (pos_nx == 5'd0) & ~slot_nx & full_0;
  assign load_1 = fall & (pos_nx == 5'd0) &  slot_nx & full_1;

  // Ack looks at the registered full flag, so a register drained this cycle
  // only becomes acceptable on the next cycle.
  assign ack              = aud.audio_in_vld & ~{full_1, full_0} & {2{rst}};
  assign aud.audio_in_ack = ack;

  // LRCLK is taken from the next frame position, giving the one-bit lead.
  assign i2s_lrclk = bit_cnt_inc[5];
  assign i2s_sdata = (bit_cnt[4:0] < 5'd24) & shreg[23];

  // BCLK divider: bclk toggles each time div_cnt wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

  // Frame position and serializer, advanced on BCLK falling events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 6'd63;
      shreg    <= '0;
      underrun <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_cnt_inc;
      if (pos_nx == 5'd0) begin
        if (slot_full) begin
          shreg <= slot_hold;
        end else begin
          shreg    <= '0;
          underrun <= 1'b1;
        end
      end else if (pos_nx < 5'd24) begin
        shreg <= {shreg[22:0], 1'b0};
      end
    end
  end

  // Channel 0 holding register: capture on ack, drain on slot load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_0 <= '0;
      full_0 <= 1'b0;
    end else if (ack[0]) begin
      hold_0 <= aud.audio_in_0;
      full_0 <= 1'b1;
    end else if (load_0) begin
      full_0 <= 1'b0;
    end
  end

  // Channel 1 holding register: capture on ack, drain on slot load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_1 <= '0;
      full_1 <= 1'b0;
    end else if (ack[1]) begin
      hold_1 <= aud.audio_in_1;
      full_1 <= 1'b1;
    end else if (load_1) begin
      full_1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with BCLK_DIV = 2 (BCLK = 4 clk, frame = 256 clk).
// An independent I2S receiver decodes the link on BCLK rising edges.
module tb_i2s_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bclk, lrclk, sdata, underrun;

  i2s_tx_if aud ();

  i2s_tx #(.BCLK_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .aud       (aud),
    .i2s_bclk  (bclk),
    .i2s_lrclk (lrclk),
    .i2s_sdata (sdata),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Receiver: the bit sampled when LRCLK changes is the previous slot's pad
  // bit; the next 24 bits are the word of the new channel, MSB first.
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] dword = '0;
  int          dcnt  = -1;
  logic        prev_lr = 1'b0;
  logic        dch     = 1'b0;
  int          pad_err = 0;
  int          len_err = 0;

  always @(posedge bclk or negedge rst) begin
    if (!rst) begin
      dcnt    = -1;
      prev_lr = 1'b0;
      dch     = 1'b0;
    end else begin
      if (lrclk !== prev_lr) begin
        dcnt    = 0;
        dch     = lrclk;
        prev_lr = lrclk;
      end else begin
        dcnt = dcnt + 1;
      end
      if (dcnt >= 1 && dcnt <= 24) begin
        dword = {dword[22:0], sdata};
        if (dcnt == 24) begin
          if (dch) q1.push_back(dword);
          else     q0.push_back(dword);
        end
      end else if (sdata !== 1'b0) begin
        pad_err++;
      end
      if (dcnt > 31) len_err++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset(input logic [1:0] v, input logic [23:0] d0, input logic [23:0] d1);
    @(negedge clk);
    rst = 1'b0;
    aud.audio_in_vld = v;
    aud.audio_in_0   = d0;
    aud.audio_in_1   = d1;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    pad_err = 0;
    len_err = 0;
    rst = 1'b1;
  endtask

  task automatic wait_words(input int n0, input int n1, input int limit, output logic ok);
    for (int i = 0; i < limit && !(q0.size() >= n0 && q1.size() >= n1); i++)
      @(negedge clk);
    ok = (q0.size() >= n0 && q1.size() >= n1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    aud.audio_in_vld = 2'b11;
    aud.audio_in_0   = 24'h111111;
    aud.audio_in_1   = 24'h222222;
    repeat (2) @(negedge clk);
    #1;
    total++; if (aud.audio_in_ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", aud.audio_in_ack); end
    total++; if (bclk !== 1'b0) begin bad++; $display("FAIL reset_bclk: got %b want 0", bclk); end
    total++; if (lrclk !== 1'b0) begin bad++; $display("FAIL reset_lrclk: got %b want 0", lrclk); end
    total++; if (sdata !== 1'b0) begin bad++; $display("FAIL reset_sdata: got %b want 0", sdata); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_first_fall();
    int rise_at = -1;
    int fall_at = -1;
    logic ur3 = 1'bx;
    logic ur4 = 1'bx;
    do_reset(2'b00, 24'h0, 24'h0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bclk === 1'b1 && rise_at < 0) rise_at = c;
      if (bclk === 1'b0 && rise_at >= 0 && fall_at < 0) fall_at = c;
      if (c == 3) ur3 = underrun;
      if (c == 4) ur4 = underrun;
    end
    total++; if (rise_at != 2) begin bad++; $display("FAIL first_rise: got %0d want 2", rise_at); end
    total++; if (fall_at != 4) begin bad++; $display("FAIL first_fall: got %0d want 4", fall_at); end
    total++; if (ur3 !== 1'b0) begin bad++; $display("FAIL underrun_before_slot: got %b want 0", ur3); end
    total++; if (ur4 !== 1'b1) begin bad++; $display("FAIL underrun_at_slot: got %b want 1", ur4); end
  endtask

  task automatic test_idle_frames();
    int rises = 0;
    int lr_tog = 0;
    int ones = 0;
    logic pb = bclk;
    logic pl = lrclk;
    repeat (512) begin
      @(posedge clk); #1;
      if (bclk === 1'b1 && pb === 1'b0) rises++;
      if (lrclk !== pl) lr_tog++;
      if (sdata !== 1'b0) ones++;
      pb = bclk;
      pl = lrclk;
    end
    total++; if (rises != 128) begin bad++; $display("FAIL idle_bclk_rises: got %0d want 128", rises); end
    total++; if (lr_tog != 4) begin bad++; $display("FAIL idle_lrclk_toggles: got %0d want 4", lr_tog); end
    total++; if (ones != 0) begin bad++; $display("FAIL idle_sdata_ones: got %0d want 0", ones); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL idle_underrun: got %b want 1", underrun); end
    total++; if (len_err != 0) begin bad++; $display("FAIL idle_slot_len: got %0d want 0", len_err); end
  endtask

  task automatic test_basic();
    logic ok;
    do_reset(2'b11, 24'hA5A5A5, 24'h0F0F01);
    #1;
    total++; if (aud.audio_in_ack !== 2'b11) begin bad++; $display("FAIL basic_ack: got %b want 11", aud.audio_in_ack); end
    @(negedge clk); #1;
    total++; if (aud.audio_in_ack !== 2'b00) begin bad++; $display("FAIL basic_ack_full: got %b want 00", aud.audio_in_ack); end
    aud.audio_in_vld = 2'b00;
    wait_words(1, 1, 800, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_words: got %0d/%0d want 1/1", q0.size(), q1.size()); end
    if (ok) begin
      total++; if (q0[0] !== 24'hA5A5A5) begin bad++; $display("FAIL basic_ch0: got %h want a5a5a5", q0[0]); end
      total++; if (q1[0] !== 24'h0F0F01) begin bad++; $display("FAIL basic_ch1: got %h want 0f0f01", q1[0]); end
    end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun: got %b want 0", underrun); end
    total++; if (pad_err != 0) begin bad++; $display("FAIL basic_pad: got %0d want 0", pad_err); end
    total++; if (len_err != 0) begin bad++; $display("FAIL basic_slot_len: got %0d want 0", len_err); end
  endtask

  task automatic test_ack_blocked();
    logic ok;
    int first = -1;
    do_reset(2'b01, 24'h123456, 24'h0);
    #1;
    total++; if (aud.audio_in_ack !== 2'b01) begin bad++; $display("FAIL blocked_first_ack: got %b want 01", aud.audio_in_ack); end
    @(negedge clk);
    aud.audio_in_0 = 24'h654321;
    #1;
    total++; if (aud.audio_in_ack[0] !== 1'b0) begin bad++; $display("FAIL blocked_ack_full: got %b want 0", aud.audio_in_ack[0]); end
    for (int c = 2; c <= 10 && first < 0; c++) begin
      @(negedge clk); #1;
      if (aud.audio_in_ack[0] === 1'b1) first = c;
    end
    @(negedge clk);
    aud.audio_in_vld = 2'b00;
    total++; if (first != 4) begin bad++; $display("FAIL blocked_ack_cycle: got %0d want 4", first); end
    wait_words(2, 0, 1200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL blocked_words: got %0d want 2", q0.size()); end
    if (ok) begin
      total++; if (q0[0] !== 24'h123456) begin bad++; $display("FAIL blocked_word0: got %h want 123456", q0[0]); end
      total++; if (q0[1] !== 24'h654321) begin bad++; $display("FAIL blocked_word1: got %h want 654321", q0[1]); end
    end
  endtask

  task automatic test_load_cycle_vld();
    logic ok;
    do_reset(2'b01, 24'h0ABCDE, 24'h0);
    @(negedge clk);
    aud.audio_in_vld = 2'b00;
    repeat (2) @(negedge clk);
    aud.audio_in_0   = 24'h13579B;
    aud.audio_in_vld = 2'b01;
    #1;
    total++; if (aud.audio_in_ack[0] !== 1'b0) begin bad++; $display("FAIL loadcyc_ack_same: got %b want 0", aud.audio_in_ack[0]); end
    @(negedge clk); #1;
    total++; if (aud.audio_in_ack[0] !== 1'b1) begin bad++; $display("FAIL loadcyc_ack_next: got %b want 1", aud.audio_in_ack[0]); end
    @(negedge clk);
    aud.audio_in_vld = 2'b00;
    wait_words(3, 0, 1500, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL loadcyc_words: got %0d want 3", q0.size()); end
    if (ok) begin
      total++; if (q0[0] !== 24'h0ABCDE) begin bad++; $display("FAIL loadcyc_word0: got %h want 0abcde", q0[0]); end
      total++; if (q0[1] !== 24'h13579B) begin bad++; $display("FAIL loadcyc_word1: got %h want 13579b", q0[1]); end
      total++; if (q0[2] !== 24'h000000) begin bad++; $display("FAIL loadcyc_word2: got %h want 000000", q0[2]); end
    end
  endtask

  task automatic test_ramp();
    logic ok;
    logic [1:0] a;
    int k0 = 0;
    int k1 = 0;
    do_reset(2'b11, 24'h000000, 24'hFFFFFF);
    for (int c = 0; c < 4000 && (k0 < 8 || k1 < 8); c++) begin
      #1;
      a = aud.audio_in_ack;
      @(posedge clk); #1;
      if (a[0]) begin
        k0++;
        if (k0 < 8) aud.audio_in_0 = 24'(k0);
        else        aud.audio_in_vld[0] = 1'b0;
      end
      if (a[1]) begin
        k1++;
        if (k1 < 8) aud.audio_in_1 = ~24'(k1);
        else        aud.audio_in_vld[1] = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (k0 != 8 || k1 != 8) begin bad++; $display("FAIL ramp_source: got %0d/%0d want 8/8", k0, k1); end
    wait_words(8, 8, 3000, ok);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ramp_underrun: got %b want 0", underrun); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ramp_words: got %0d/%0d want 8/8", q0.size(), q1.size()); end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (q0[i] !== 24'(i)) begin bad++; $display("FAIL ramp_ch0[%0d]: got %h want %h", i, q0[i], 24'(i)); end
        total++; if (q1[i] !== ~24'(i)) begin bad++; $display("FAIL ramp_ch1[%0d]: got %h want %h", i, q1[i], ~24'(i)); end
      end
    end
    total++; if (pad_err != 0) begin bad++; $display("FAIL ramp_pad: got %0d want 0", pad_err); end
  endtask

  task automatic test_mid_reset();
    logic ok;
    int rise_at = -1;
    int fall_at = -1;
    logic ur3 = 1'bx;
    logic ur4 = 1'bx;
    do_reset(2'b01, 24'hFFFFFF, 24'h0);
    repeat (302) @(posedge clk);
    @(negedge clk);
    total++; if ({bclk, sdata, underrun, lrclk} !== 4'b1110) begin bad++; $display("FAIL midrst_before: got %b want 1110", {bclk, sdata, underrun, lrclk}); end
    rst = 1'b0;
    #1;
    total++; if ({bclk, sdata, underrun, lrclk} !== 4'b0000) begin bad++; $display("FAIL midrst_outputs: got %b want 0000", {bclk, sdata, underrun, lrclk}); end
    total++; if (aud.audio_in_ack !== 2'b00) begin bad++; $display("FAIL midrst_ack: got %b want 00", aud.audio_in_ack); end
    do_reset(2'b00, 24'h0, 24'h0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bclk === 1'b1 && rise_at < 0) rise_at = c;
      if (bclk === 1'b0 && rise_at >= 0 && fall_at < 0) fall_at = c;
      if (c == 3) ur3 = underrun;
      if (c == 4) ur4 = underrun;
    end
    total++; if (rise_at != 2 || fall_at != 4) begin bad++; $display("FAIL midrst_restart: got %0d/%0d want 2/4", rise_at, fall_at); end
    total++; if ({ur3, ur4} !== 2'b01) begin bad++; $display("FAIL midrst_hold_empty: got %b want 01", {ur3, ur4}); end
    wait_words(1, 0, 400, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_words: got %0d want 1", q0.size()); end
    if (ok) begin
      total++; if (q0[0] !== 24'h000000) begin bad++; $display("FAIL midrst_word0: got %h want 000000", q0[0]); end
    end
  endtask

  initial begin
    aud.audio_in_vld = 2'b00;
    aud.audio_in_0   = '0;
    aud.audio_in_1   = '0;
    test_reset();
    test_first_fall();
    test_idle_frames();
    test_basic();
    test_ack_blocked();
    test_load_cycle_vld();
    test_ramp();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
